// File: rtl/vga_timing_pkg.sv
// VGA 640x480@60 Hz timing constants and the shared 10-bit coordinate type.
package vga_timing_pkg;

  localparam int unsigned COORD_W = 10;

  // 640x480 defaults, in pixels (horizontal) and lines (vertical)
  localparam int unsigned VGA_HD      = 640;
  localparam int unsigned VGA_HF      = 16;
  localparam int unsigned VGA_HR      = 96;
  localparam int unsigned VGA_HB      = 48;
  localparam int unsigned VGA_VD      = 480;
  localparam int unsigned VGA_VF      = 10;
  localparam int unsigned VGA_VR      = 2;
  localparam int unsigned VGA_VB      = 33;
  localparam int unsigned VGA_CLK_DIV = 4;

  localparam int unsigned VGA_H_TOTAL = VGA_HD + VGA_HF + VGA_HR + VGA_HB;
  localparam int unsigned VGA_V_TOTAL = VGA_VD + VGA_VF + VGA_VR + VGA_VB;

  // Screen coordinate, also used by the pixel generator for object bounds
  typedef logic [COORD_W-1:0] coord_t;

  // Inclusive range test on a coordinate
  function automatic logic in_range(coord_t v, coord_t lo, coord_t hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/pixel_tick_div.sv
// Mod-CLK_DIV clock divider producing a one-clk pixel-rate enable.
module pixel_tick_div
  import vga_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV = VGA_CLK_DIV
) (
  input  logic clk,
  input  logic rst,
  output logic p_tick
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  if (CLK_DIV == 0) begin : g_div_err
    $error("pixel_tick_div: CLK_DIV must be at least 1");
  end

  logic [DIV_W-1:0] r_div_cnt;
  logic             w_last;

  assign w_last = (r_div_cnt == DIV_W'(CLK_DIV - 1));

  // Divider counter, wraps at CLK_DIV-1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div_cnt <= '0;
    end else if (w_last) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + DIV_W'(1);
    end
  end

  // Gated by reset so CLK_DIV = 1 still reads 0 while reset is held
  assign p_tick = w_last & ~rst;

endmodule

// File: rtl/vga_sync.sv
// VGA sync generator: pixel counters, hsync/vsync, video_on, frame_tick.
// Build option VGA_SYNC_OUTREG_EN: hsync/vsync/video_on from flip-flops
// loaded with the decode of the next counter values (same cycle timing).
module vga_sync
  import vga_timing_pkg::*;
#(
  parameter int unsigned HD      = VGA_HD,
  parameter int unsigned HF      = VGA_HF,
  parameter int unsigned HR      = VGA_HR,
  parameter int unsigned HB      = VGA_HB,
  parameter int unsigned VD      = VGA_VD,
  parameter int unsigned VF      = VGA_VF,
  parameter int unsigned VR      = VGA_VR,
  parameter int unsigned VB      = VGA_VB,
  parameter int unsigned CLK_DIV = VGA_CLK_DIV
) (
  input  logic               clk,
  input  logic               rst,
  output logic               hsync,
  output logic               vsync,
  output logic               video_on,
  output logic               p_tick,
  output logic               frame_tick,
  output logic [COORD_W-1:0] pixel_x,
  output logic [COORD_W-1:0] pixel_y
);

  localparam int unsigned H_TOTAL = HD + HF + HR + HB;
  localparam int unsigned V_TOTAL = VD + VF + VR + VB;

  if ((H_TOTAL > (1 << COORD_W)) || (V_TOTAL > (1 << COORD_W))) begin : g_size_err
    $error("vga_sync: H_TOTAL/V_TOTAL do not fit the coordinate width");
  end

  coord_t r_h_cnt;
  coord_t r_v_cnt;
  coord_t w_h_next;
  coord_t w_v_next;
  logic   w_p_tick;
  logic   w_h_last;
  logic   w_v_last;

  function automatic logic hsync_dec(coord_t h);
    return !in_range(h, COORD_W'(HD + HF), COORD_W'(HD + HF + HR - 1));
  endfunction

  function automatic logic vsync_dec(coord_t v);
    return !in_range(v, COORD_W'(VD + VF), COORD_W'(VD + VF + VR - 1));
  endfunction

  function automatic logic video_dec(coord_t h, coord_t v);
    return (h < COORD_W'(HD)) && (v < COORD_W'(VD));
  endfunction

  pixel_tick_div #(
    .CLK_DIV (CLK_DIV)
  ) u_tick_div (
    .clk    (clk),
    .rst    (rst),
    .p_tick (w_p_tick)
  );

  assign w_h_last = (r_h_cnt == COORD_W'(H_TOTAL - 1));
  assign w_v_last = (r_v_cnt == COORD_W'(V_TOTAL - 1));
  assign w_h_next = w_h_last ? '0 : r_h_cnt + COORD_W'(1);
  assign w_v_next = !w_h_last ? r_v_cnt :
                    (w_v_last ? '0 : r_v_cnt + COORD_W'(1));

  // Pixel/line counters advance only on the pixel enable
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (w_p_tick) begin
      r_h_cnt <= w_h_next;
      r_v_cnt <= w_v_next;
    end
  end

`ifdef VGA_SYNC_OUTREG_EN
  logic r_hsync;
  logic r_vsync;
  logic r_video_on;

  // Registered decode of the next position keeps timing aligned with the counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hsync    <= 1'b1;
      r_vsync    <= 1'b1;
      r_video_on <= 1'b1;
    end else if (w_p_tick) begin
      r_hsync    <= hsync_dec(w_h_next);
      r_vsync    <= vsync_dec(w_v_next);
      r_video_on <= video_dec(w_h_next, w_v_next);
    end
  end

  assign hsync    = r_hsync;
  assign vsync    = r_vsync;
  assign video_on = r_video_on;
`else
  assign hsync    = hsync_dec(r_h_cnt);
  assign vsync    = vsync_dec(r_v_cnt);
  assign video_on = video_dec(r_h_cnt, r_v_cnt);
`endif

  assign p_tick     = w_p_tick;
  assign frame_tick = w_p_tick & w_h_last & w_v_last;
  assign pixel_x    = r_h_cnt;
  assign pixel_y    = r_v_cnt;

endmodule

// File: tb/tb_vga_sync.sv
// Directed bench for vga_sync: default 640x480 instance plus a tiny-timing instance.
module tb_vga_sync;

  logic       clk;
  logic       rst;
  logic       hsync, vsync, video_on, p_tick, frame_tick;
  logic [9:0] pixel_x, pixel_y;
  logic       s_hsync, s_vsync, s_video_on, s_p_tick, s_frame_tick;
  logic [9:0] s_pixel_x, s_pixel_y;

  int checks;
  int failures;
  int n;  // clock edges since the latest reset release

  typedef struct {
    int   n;
    int   x;
    int   y;
    logic hs;
    logic vo;
    logic pt;
  } line_pt_t;

  line_pt_t line_pts [8] = '{
    '{2559, 639, 0, 1'b1, 1'b1, 1'b1},
    '{2560, 640, 0, 1'b1, 1'b0, 1'b0},
    '{2623, 655, 0, 1'b1, 1'b0, 1'b1},
    '{2624, 656, 0, 1'b0, 1'b0, 1'b0},
    '{3007, 751, 0, 1'b0, 1'b0, 1'b1},
    '{3008, 752, 0, 1'b1, 1'b0, 1'b0},
    '{3199, 799, 0, 1'b1, 1'b0, 1'b1},
    '{3200,   0, 1, 1'b1, 1'b1, 1'b0}
  };

  vga_sync u_dut (
    .clk        (clk),
    .rst        (rst),
    .hsync      (hsync),
    .vsync      (vsync),
    .video_on   (video_on),
    .p_tick     (p_tick),
    .frame_tick (frame_tick),
    .pixel_x    (pixel_x),
    .pixel_y    (pixel_y)
  );

  vga_sync #(
    .HD(4), .HF(1), .HR(2), .HB(1),
    .VD(3), .VF(1), .VR(1), .VB(1),
    .CLK_DIV(1)
  ) u_small (
    .clk        (clk),
    .rst        (rst),
    .hsync      (s_hsync),
    .vsync      (s_vsync),
    .video_on   (s_video_on),
    .p_tick     (s_p_tick),
    .frame_tick (s_frame_tick),
    .pixel_x    (s_pixel_x),
    .pixel_y    (s_pixel_y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    n++;
  endtask

  task automatic step_to(input int target);
    while (n < target) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    n   = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({pixel_x, pixel_y} !== 20'd0) begin
      failures++;
      $display("FAIL reset_xy: got x=%0d y=%0d want 0 0", pixel_x, pixel_y);
    end
    checks++;
    if ({p_tick, frame_tick} !== 2'b00) begin
      failures++;
      $display("FAIL reset_ticks: got p=%b f=%b want 0 0", p_tick, frame_tick);
    end
    checks++;
    if ({hsync, vsync, video_on} !== 3'b111) begin
      failures++;
      $display("FAIL reset_sync: got hs=%b vs=%b vo=%b want 1 1 1", hsync, vsync, video_on);
    end
    checks++;
    if ({s_p_tick, s_frame_tick, s_hsync, s_vsync, s_video_on} !== 5'b00111 ||
        {s_pixel_x, s_pixel_y} !== 20'd0) begin
      failures++;
      $display("FAIL reset_small: got p=%b f=%b hs=%b vs=%b vo=%b x=%0d y=%0d want 0 0 1 1 1 0 0",
               s_p_tick, s_frame_tick, s_hsync, s_vsync, s_video_on, s_pixel_x, s_pixel_y);
    end
    @(negedge clk);
    rst = 1'b0;
    n   = 0;
  endtask

  // Expects to be called right after a reset release
  task automatic test_first_tick();
    for (int k = 1; k <= 4; k++) begin
      tick();
      checks++;
      if (pixel_x !== ((k == 4) ? 10'd1 : 10'd0)) begin
        failures++;
        $display("FAIL first_tick_x edge %0d: got %0d want %0d", k, pixel_x, (k == 4) ? 1 : 0);
      end
      checks++;
      if (p_tick !== (k == 3)) begin
        failures++;
        $display("FAIL first_tick_p edge %0d: got %b want %b", k, p_tick, (k == 3));
      end
      if (k == 1) begin
        checks++;
        if (s_pixel_x !== 10'd1 || s_p_tick !== 1'b1) begin
          failures++;
          $display("FAIL small_first_tick: got x=%0d p=%b want 1 1", s_pixel_x, s_p_tick);
        end
      end
    end
  endtask

  task automatic test_line();
    for (int i = 0; i < 8; i++) begin
      step_to(line_pts[i].n);
      checks++;
      if (pixel_x !== 10'(line_pts[i].x) || pixel_y !== 10'(line_pts[i].y) ||
          hsync !== line_pts[i].hs || video_on !== line_pts[i].vo ||
          p_tick !== line_pts[i].pt || vsync !== 1'b1 || frame_tick !== 1'b0) begin
        failures++;
        $display("FAIL line_clk%0d: got x=%0d y=%0d hs=%b vs=%b vo=%b p=%b f=%b want x=%0d y=%0d hs=%b vs=1 vo=%b p=%b f=0",
                 n, pixel_x, pixel_y, hsync, vsync, video_on, p_tick, frame_tick,
                 line_pts[i].x, line_pts[i].y, line_pts[i].hs, line_pts[i].vo, line_pts[i].pt);
      end
    end
  endtask

  task automatic test_mid_reset();
    step_to(4403);
    checks++;
    if (pixel_x !== 10'd300 || pixel_y !== 10'd1 || p_tick !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset_pos: got x=%0d y=%0d p=%b want 300 1 1", pixel_x, pixel_y, p_tick);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({pixel_x, pixel_y} !== 20'd0 || {hsync, vsync, video_on} !== 3'b111 ||
        {p_tick, frame_tick} !== 2'b00) begin
      failures++;
      $display("FAIL async_reset: got x=%0d y=%0d hs=%b vs=%b vo=%b p=%b f=%b want 0 0 1 1 1 0 0",
               pixel_x, pixel_y, hsync, vsync, video_on, p_tick, frame_tick);
    end
    checks++;
    if (s_p_tick !== 1'b0 || {s_pixel_x, s_pixel_y} !== 20'd0) begin
      failures++;
      $display("FAIL async_reset_small: got x=%0d y=%0d p=%b want 0 0 0", s_pixel_x, s_pixel_y, s_p_tick);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n   = 0;
  endtask

  // Small instance: H_TOTAL=8, V_TOTAL=6, one pixel per clk
  task automatic test_small_frames();
    int   h, v, ft_seen;
    logic e_hs, e_vs, e_vo, e_ft;
    ft_seen = 0;
    while (n < 100) begin
      tick();
      h    = n % 8;
      v    = (n / 8) % 6;
      e_hs = !(h >= 5 && h <= 6);
      e_vs = (v != 4);
      e_vo = (h < 4) && (v < 3);
      e_ft = (n % 48 == 47);
      if (s_frame_tick === 1'b1) ft_seen++;
      checks++;
      if (s_pixel_x !== 10'(h) || s_pixel_y !== 10'(v) || s_hsync !== e_hs ||
          s_vsync !== e_vs || s_video_on !== e_vo || s_frame_tick !== e_ft || s_p_tick !== 1'b1) begin
        failures++;
        $display("FAIL small_clk%0d: got x=%0d y=%0d hs=%b vs=%b vo=%b f=%b p=%b want x=%0d y=%0d hs=%b vs=%b vo=%b f=%b p=1",
                 n, s_pixel_x, s_pixel_y, s_hsync, s_vsync, s_video_on, s_frame_tick, s_p_tick,
                 h, v, e_hs, e_vs, e_vo, e_ft);
      end
    end
    checks++;
    if (ft_seen !== 2) begin
      failures++;
      $display("FAIL small_frame_count: got %0d want 2", ft_seen);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    test_reset();
    test_first_tick();
    test_line();
    test_mid_reset();
    test_first_tick();
    test_small_frames();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_sync.md
Name: vga_sync

Overview:
- Generates VGA 640x480@60 Hz timing from the 100 MHz system clock.
- Drives the pixel generation circuit with pixel_x, pixel_y and video_on, and drives the board with hsync and vsync.
- Provides p_tick (pixel-rate enable) and frame_tick (once per frame) so downstream logic, such as paddle and ball motion, can update once per frame.
- Sits directly upstream of pixel_generation_circuit; both blocks share clk and rst.

Parameters:
- HD, 640, horizontal display pixels
- HF, 16, horizontal front porch (pixels)
- HR, 96, horizontal sync pulse width (pixels)
- HB, 48, horizontal back porch (pixels)
- VD, 480, vertical display lines
- VF, 10, vertical front porch (lines)
- VR, 2, vertical sync pulse width (lines)
- VB, 33, vertical back porch (lines)
- CLK_DIV, 4, system clocks per pixel; 100 MHz / 4 gives 25 MHz

Ports:
- clk  in  1  system clock, 100 MHz
- rst  in  1  asynchronous, active-high reset
- hsync  out  1  horizontal sync, active low
- vsync  out  1  vertical sync, active low
- video_on  out  1  high while (pixel_x, pixel_y) is inside the visible area
- p_tick  out  1  one-clk enable pulse at pixel rate
- frame_tick  out  1  one-clk pulse on the last pixel of each frame
- pixel_x  out  10  current horizontal count, 0..H_TOTAL-1
- pixel_y  out  10  current vertical count, 0..V_TOTAL-1

Behaviour:
- Derived constants: H_TOTAL = HD+HF+HR+HB = 800; V_TOTAL = VD+VF+VR+VB = 525. Both must fit in 10 bits; elaboration-time error otherwise.
- Reset: asserting rst immediately clears div_cnt, h_cnt and v_cnt to 0, asynchronously and regardless of the clock.
- Outputs while reset is held:
  - pixel_x = 0, pixel_y = 0
  - p_tick = 0, frame_tick = 0
  - hsync = 1, vsync = 1
  - video_on = 1, because (0,0) is visible
- Divider:
  - div_cnt counts 0..CLK_DIV-1 and wraps.
  - p_tick = (div_cnt == CLK_DIV-1), combinational. The first p_tick occurs CLK_DIV clocks after reset release.
  - CLK_DIV = 1 makes p_tick constantly high outside reset.
- Horizontal counter: on each p_tick, h_cnt increments, wrapping from H_TOTAL-1 to 0.
- Vertical counter: v_cnt increments only on the p_tick where h_cnt wraps, and itself wraps from V_TOTAL-1 to 0. When both wrap on the same tick, both become 0 on the same clock edge.
- Counters hold their value between p_ticks. pixel_x = h_cnt and pixel_y = v_cnt directly, with no extra latency.
- hsync = 0 iff HD+HF <= h_cnt <= HD+HF+HR-1, i.e. 656..751.
- vsync = 0 iff VD+VF <= v_cnt <= VD+VF+VR-1, i.e. 490..491.
- video_on = (h_cnt < HD) && (v_cnt < VD).
- frame_tick = p_tick && h_cnt == H_TOTAL-1 && v_cnt == V_TOTAL-1, exactly one clk wide.
- All output changes take effect on the clock edge where p_tick is high. Between ticks, all outputs are stable.
- Reset mid-frame: outputs return to their reset values at once. Counting resumes from (0,0) with a fresh CLK_DIV-clock wait before the first p_tick.

Optional Feature:
- Macro: VGA_SYNC_OUTREG_EN.
- When defined:
  - hsync, vsync and video_on come from flip-flops, loaded on p_tick with the decode of the *next* h_cnt/v_cnt values.
  - Cycle timing relative to pixel_x/pixel_y is therefore identical to the combinational version, but the outputs are glitch-free.
  - Flip-flop reset values: hsync = 1, vsync = 1, video_on = 1.
- When undefined: hsync, vsync and video_on are combinational decodes of the counters, as described in Behaviour.
- Either build must produce bit-identical waveforms at clk edges.

Decomposition:
- Package vga_timing_pkg:
  - 640x480 default constants (HD..VB, CLK_DIV)
  - derived H_TOTAL and V_TOTAL
  - a 10-bit coordinate typedef, shared with pixel_generation_circuit for its object-boundary constants
- Sub-module pixel_tick_div:
  - mod-CLK_DIV counter with async reset, producing p_tick
  - instantiated once; h/v counting stays in vga_sync

Test Plan:
- Reset release, CLK_DIV = 4 -> first p_tick at clk 4 after release, then every 4 clks; pixel_x = 1 after the first tick.
- Run one line -> hsync falls when pixel_x = 656 (clk 2624) and rises at 752. video_on drops when pixel_x = 640. pixel_x wraps to 0 and pixel_y becomes 1 at clk 3200.
- Run one full frame -> vsync low exactly while pixel_y is 490..491 (6400 clks). frame_tick is a single-clk pulse at clk 1,680,000. (0,0) follows immediately.
- Assert rst asynchronously mid-line at pixel (300, 200), between clk edges -> pixel_x and pixel_y are 0 immediately; hsync = vsync = 1; no p_tick until 4 clks after release.
- Overrides CLK_DIV = 1, HD = 4, HF = 1, HR = 2, HB = 1, VD = 3, VF = 1, VR = 1, VB = 1 -> H_TOTAL = 8, V_TOTAL = 6. hsync is low at h = 5..6, vsync is low at v = 4, frame_tick pulses every 48 clks.
- Build with and without VGA_SYNC_OUTREG_EN and compare hsync, vsync, video_on and pixel_x/pixel_y over 2 frames -> zero mismatches at clk edges.
